mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback from the registered instruction opcode. It drives every datapath mux and enable, and produces the 3-bit `alu_op` consumed by the ALU control decoder. It stalls in memory states until the memory handshake completes.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instruction[31:26] from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_en`  out  1  PC load enable, computed as `pc_write | (pc_write_cond & zero)`
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A register
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- `ext_zero`  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- `pc_source`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- `alu_op`  out  3  operation class: 000 ADD, 001 SUB, 010 R-type, 011 AND, 100 OR, 101 XOR, 110 SLT
- `illegal_op`  out  1  one-cycle pulse on an unrecognised opcode
- `state`  out  4  current state, for debug

## Operation
- States, 4-bit encoding: INIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, IMMEX=10, IMMWB=11, JUMP=12.
- Outputs are decoded from state. Any output not listed for a state is 0.
- INIT: all outputs 0. Goes to FETCH next cycle.
- FETCH: mem_read=1, alu_src_b=01, alu_op=000.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=000. Next state by opcode:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000, 001100, 001101, 001110, 001010 → IMMEX
  - any other opcode → FETCH, with illegal_op=1 for this DECODE cycle
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1. Then FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_op=010. Then ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_op=001, pc_source=01, pc_write_cond=1. Then FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10. Then IMMWB.
  - alu_op by opcode: addi 000, andi 011, ori 100, xori 101, slti 110.
  - ext_zero=1 for andi, ori and xori.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- JUMP: pc_source=10, pc_write=1. Then FETCH.
- `opcode` is only meaningful after FETCH has completed.

## Timing
- Reset (rst_n=0): state=INIT immediately, asynchronously. All outputs 0, including pc_en.
- Deassertion: first FETCH is the cycle after the first clock edge with rst_n=1.
- Cycles per instruction with mem_ready=1 throughout:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - I-type ALU: 4
  - illegal opcode: 2
- Each mem_ready=0 cycle adds one cycle in FETCH, MEMRD or MEMWR. No output changes during the stall, except that ir_write and pc_write stay 0.
- pc_en is combinational from state, mem_ready and zero within the cycle.
- Reset asserted mid-instruction: abandons the instruction. No further reg_write or mem_write is issued.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings
  - opcode constants
  - alu_op constants, also used by the ALU control decoder
  - alu_src_b and pc_source select constants
- One combinational sub-module `opcode_class_decode`: maps opcode to {is_rtype, is_lw, is_sw, is_beq, is_j, is_imm, imm_alu_op, ext_zero, illegal}.
- State register plus a next-state/output block in the top module.

## Test plan
- Reset: hold rst_n=0 with opcode=000000. Required: state=0, all outputs 0. Release rst_n. Required: state=1 after one edge, mem_read=1, pc_en=1 with mem_ready=1.
- R-type (opcode=000000): state sequence 1,2,7,8,1. alu_op=010 in EXEC. reg_dst=1 and reg_write=1 in ALUWB.
- lw (opcode=100011) with mem_ready=0 for 2 cycles in MEMRD: sequence 1,2,3,4,4,4,5,1. iord=1 throughout MEMRD. mem_to_reg=1 and reg_write=1 in MEMWB.
- beq (opcode=000100):
  - with zero=1: pc_en=1, pc_source=01, alu_op=001 in BRANCH
  - repeated with zero=0: pc_en=0
- I-type: ori (001101) gives alu_op=100 and ext_zero=1 in IMMEX. slti (001010) gives alu_op=110 and ext_zero=0. Sequence 1,2,10,11,1 in both cases.
- Illegal opcode 111111: illegal_op=1 for exactly one DECODE cycle, then FETCH. Assert rst_n=0 mid-MEMWR: state=0 and mem_write=0 at once.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM and the ALU control decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       is_rtype;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_j;
    logic       is_imm;
    logic [2:0] imm_alu_op;
    logic       ext_zero;
    logic       illegal;
  } op_class_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the main control FSM (master) and the multicycle datapath (slave).
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] pc_source;
  logic [2:0] alu_op;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, ext_zero, pc_source, alu_op,
           illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, ext_zero, pc_source, alu_op,
           illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control_decode.sv
// Combinational opcode classifier: instruction class, I-type ALU operation and extension mode.
module opcode_class_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output op_class_t  o_cls
);
  always_comb begin
    o_cls = '0;
    case (i_opcode)
      OP_RTYPE: o_cls.is_rtype = 1'b1;
      OP_LW:    o_cls.is_lw    = 1'b1;
      OP_SW:    o_cls.is_sw    = 1'b1;
      OP_BEQ:   o_cls.is_beq   = 1'b1;
      OP_J:     o_cls.is_j     = 1'b1;
      OP_ADDI:  begin o_cls.is_imm = 1'b1; o_cls.imm_alu_op = ALU_ADD; end
      OP_ANDI:  begin o_cls.is_imm = 1'b1; o_cls.imm_alu_op = ALU_AND; o_cls.ext_zero = 1'b1; end
      OP_ORI:   begin o_cls.is_imm = 1'b1; o_cls.imm_alu_op = ALU_OR;  o_cls.ext_zero = 1'b1; end
      OP_XORI:  begin o_cls.is_imm = 1'b1; o_cls.imm_alu_op = ALU_XOR; o_cls.ext_zero = 1'b1; end
      OP_SLTI:  begin o_cls.is_imm = 1'b1; o_cls.imm_alu_op = ALU_SLT; end
      default:  o_cls.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state logic and
// Moore output decode (plus the mem_ready-qualified fetch strobes and branch PC enable).
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  mips_multicycle_control_if.master         bus
);
  state_t    r_state;
  state_t    w_next;
  op_class_t w_cls;
  logic      w_pc_write;
  logic      w_pc_write_cond;

  opcode_class_decode u_dec (
    .i_opcode (bus.opcode),
    .o_cls    (w_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_INIT;
    case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_cls.is_rtype)                 w_next = S_EXEC;
        else if (w_cls.is_lw | w_cls.is_sw) w_next = S_MEMADR;
        else if (w_cls.is_beq)              w_next = S_BRANCH;
        else if (w_cls.is_j)                w_next = S_JUMP;
        else if (w_cls.is_imm)              w_next = S_IMMEX;
        else                                w_next = S_FETCH;
      end
      S_MEMADR: w_next = w_cls.is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB:  w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_INIT;
    endcase
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SRCB_B;
    bus.ext_zero    = 1'b0;
    bus.pc_source   = PCSRC_ALU;
    bus.alu_op      = ALU_ADD;
    bus.illegal_op  = 1'b0;
    case (r_state)
      // Instruction and PC are only captured on the cycle memory actually delivers.
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        w_pc_write    = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b  = SRCB_IMM_SH;
        bus.illegal_op = w_cls.illegal;
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEMRD:  begin bus.mem_read  = 1'b1; bus.iord = 1'b1; end
      S_MEMWB:  begin bus.mem_to_reg = 1'b1; bus.reg_write = 1'b1; end
      S_MEMWR:  begin bus.mem_write = 1'b1; bus.iord = 1'b1; end
      S_EXEC:   begin bus.alu_src_a = 1'b1; bus.alu_op = ALU_RTYPE; end
      S_ALUWB:  begin bus.reg_dst   = 1'b1; bus.reg_write = 1'b1; end
      S_BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_op      = ALU_SUB;
        bus.pc_source   = PCSRC_ALUOUT;
        w_pc_write_cond = 1'b1;
      end
      S_IMMEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = w_cls.imm_alu_op;
        bus.ext_zero  = w_cls.ext_zero;
      end
      S_IMMWB:  bus.reg_write = 1'b1;
      S_JUMP:   begin bus.pc_source = PCSRC_JUMP; w_pc_write = 1'b1; end
      default:  ;
    endcase
    bus.pc_en = w_pc_write | (w_pc_write_cond & bus.zero);
  end

  assign bus.state = r_state;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for the multicycle MIPS control FSM: directed scenarios plus a randomized instruction stream.
module tb_mips_multicycle_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
  } step_t;

  int    nvec = 0;
  int    nerr = 0;
  outs_t obs;
  logic [3:0] obs_st;

  function automatic outs_t observe();
    outs_t o;
    o = '{bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
          bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.ext_zero,
          bus.pc_source, bus.alu_op, bus.illegal_op};
    return o;
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
  endfunction

  // Reference: the per-state output table, written straight from the control description.
  function automatic outs_t exp_out(input logic [3:0] st, input logic [5:0] op,
                                    input logic mr, input logic z);
    outs_t o;
    o = '0;
    case (st)
      4'd1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
      4'd2:  begin o.alu_src_b = 2'b11; o.illegal_op = !legal_op(op); end
      4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd4:  begin o.mem_read = 1; o.iord = 1; end
      4'd5:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      4'd6:  begin o.mem_write = 1; o.iord = 1; end
      4'd7:  begin o.alu_src_a = 1; o.alu_op = 3'b010; end
      4'd8:  begin o.reg_dst = 1; o.reg_write = 1; end
      4'd9:  begin o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_source = 2'b01; o.pc_en = z; end
      4'd10: begin
        o.alu_src_a = 1; o.alu_src_b = 2'b10;
        case (op)
          6'b001100: begin o.alu_op = 3'b011; o.ext_zero = 1; end
          6'b001101: begin o.alu_op = 3'b100; o.ext_zero = 1; end
          6'b001110: begin o.alu_op = 3'b101; o.ext_zero = 1; end
          6'b001010: o.alu_op = 3'b110;
          default:   o.alu_op = 3'b000;
        endcase
      end
      4'd11: o.reg_write = 1;
      4'd12: begin o.pc_source = 2'b10; o.pc_en = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle's inputs, sample on the falling edge, return just after the rising edge.
  task automatic cyc(input logic mr, input logic z);
    bus.mem_ready = mr;
    bus.zero      = z;
    @(negedge clk);
    obs_st = bus.state;
    obs    = observe();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.opcode = 6'b000000; bus.mem_ready = 1'b1; bus.zero = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++; if (bus.state !== 4'd0) begin nerr++; $display("FAIL reset_state got %0d want 0", bus.state); end
    nvec++; if (observe() !== outs_t'(0)) begin nerr++; $display("FAIL reset_outs got %h want 0", observe()); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++; if (bus.state !== 4'd1) begin nerr++; $display("FAIL rel_state got %0d want 1", bus.state); end
    nvec++; if (bus.mem_read !== 1'b1 || bus.pc_en !== 1'b1) begin
      nerr++; $display("FAIL rel_fetch mem_read=%b pc_en=%b want 1 1", bus.mem_read, bus.pc_en);
    end
  endtask

  task automatic test_rtype;
    logic [3:0] seq [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
    bus.opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      nvec++; if (obs_st !== seq[i]) begin nerr++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, obs_st, seq[i]); end
      if (i == 2) begin
        nvec++; if (obs.alu_op !== 3'b010) begin nerr++; $display("FAIL rtype_aluop got %b want 010", obs.alu_op); end
      end
      if (i == 3) begin
        nvec++; if ({obs.reg_dst, obs.reg_write} !== 2'b11) begin
          nerr++; $display("FAIL rtype_wb got %b want 11", {obs.reg_dst, obs.reg_write});
        end
      end
    end
    nvec++; if (bus.state !== 4'd1) begin nerr++; $display("FAIL rtype_end got %0d want 1", bus.state); end
  endtask

  task automatic test_lw;
    logic [3:0] seq [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
    logic       mr  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      cyc(mr[i], 1'b0);
      nvec++; if (obs_st !== seq[i]) begin nerr++; $display("FAIL lw_state[%0d] got %0d want %0d", i, obs_st, seq[i]); end
      if (i >= 3 && i <= 5) begin
        nvec++; if (obs.iord !== 1'b1) begin nerr++; $display("FAIL lw_iord[%0d] got %b want 1", i, obs.iord); end
      end
      if (i == 6) begin
        nvec++; if ({obs.mem_to_reg, obs.reg_write} !== 2'b11) begin
          nerr++; $display("FAIL lw_wb got %b want 11", {obs.mem_to_reg, obs.reg_write});
        end
      end
    end
    nvec++; if (bus.state !== 4'd1) begin nerr++; $display("FAIL lw_end got %0d want 1", bus.state); end
  endtask

  task automatic test_beq;
    logic [3:0] seq [3] = '{4'd1, 4'd2, 4'd9};
    logic       zv;
    bus.opcode = 6'b000100;
    for (int r = 0; r < 2; r++) begin
      zv = (r == 0);
      for (int i = 0; i < 3; i++) begin
        cyc(1'b1, zv);
        nvec++; if (obs_st !== seq[i]) begin nerr++; $display("FAIL beq_state[%0d] got %0d want %0d", i, obs_st, seq[i]); end
      end
      nvec++; if ({obs.pc_en, obs.pc_source, obs.alu_op} !== {zv, 2'b01, 3'b001}) begin
        nerr++; $display("FAIL beq_branch zero=%b got %b want %b", zv, {obs.pc_en, obs.pc_source, obs.alu_op}, {zv, 2'b01, 3'b001});
      end
    end
  endtask

  task automatic test_imm;
    logic [5:0] ops [2] = '{6'b001101, 6'b001010};
    logic [2:0] aop [2] = '{3'b100, 3'b110};
    logic       ez  [2] = '{1'b1, 1'b0};
    logic [3:0] seq [4] = '{4'd1, 4'd2, 4'd10, 4'd11};
    for (int k = 0; k < 2; k++) begin
      bus.opcode = ops[k];
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, 1'b0);
        nvec++; if (obs_st !== seq[i]) begin nerr++; $display("FAIL imm_state[%0d][%0d] got %0d want %0d", k, i, obs_st, seq[i]); end
        if (i == 2) begin
          nvec++; if ({obs.alu_op, obs.ext_zero} !== {aop[k], ez[k]}) begin
            nerr++; $display("FAIL imm_ex op=%b got %b want %b", ops[k], {obs.alu_op, obs.ext_zero}, {aop[k], ez[k]});
          end
        end
      end
      nvec++; if (bus.state !== 4'd1) begin nerr++; $display("FAIL imm_end got %0d want 1", bus.state); end
    end
  endtask

  task automatic test_illegal;
    int pulses = 0;
    bus.opcode = 6'b111111;
    cyc(1'b1, 1'b0); pulses += int'(obs.illegal_op);
    cyc(1'b1, 1'b0); pulses += int'(obs.illegal_op);
    nvec++; if (obs_st !== 4'd2 || obs.illegal_op !== 1'b1) begin
      nerr++; $display("FAIL illegal_decode state=%0d illegal=%b want 2 1", obs_st, obs.illegal_op);
    end
    pulses += int'(bus.illegal_op);
    nvec++; if (bus.state !== 4'd1 || pulses != 1) begin
      nerr++; $display("FAIL illegal_after state=%0d pulses=%0d want 1 1", bus.state, pulses);
    end
  endtask

  task automatic test_reset_mid;
    bus.opcode = 6'b101011;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    nvec++; if (obs_st !== 4'd6 || obs.mem_write !== 1'b1) begin
      nerr++; $display("FAIL midrst_memwr state=%0d mem_write=%b want 6 1", obs_st, obs.mem_write);
    end
    rst_n = 1'b0;
    #1;
    nvec++; if (bus.state !== 4'd0 || bus.mem_write !== 1'b0) begin
      nerr++; $display("FAIL midrst_async state=%0d mem_write=%b want 0 0", bus.state, bus.mem_write);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1);
      nvec++; if (obs !== outs_t'(0) || obs_st !== 4'd0) begin
        nerr++; $display("FAIL midrst_hold state=%0d outs=%h want 0 0", obs_st, obs);
      end
    end
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    nvec++; if (obs_st !== 4'd0 || bus.state !== 4'd1) begin
      nerr++; $display("FAIL midrst_release init=%0d next=%0d want 0 1", obs_st, bus.state);
    end
  endtask

  // Random instruction stream: each instruction's state path comes from its opcode class,
  // with random memory stalls in FETCH/MEMRD/MEMWR and random don't-care inputs elsewhere.
  task automatic test_random;
    logic [5:0] legal [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                               6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
    step_t      q[$];
    logic [5:0] op;
    logic       z;
    outs_t      e;
    for (int n = 0; n < 250; n++) begin
      q.delete();
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 9)];
      bus.opcode = op;
      for (int k = $urandom_range(0, 2); k > 0; k--) q.push_back('{4'd1, 1'b0});
      q.push_back('{4'd1, 1'b1});
      q.push_back('{4'd2, 1'($urandom)});
      if (op == 6'b000000) begin
        q.push_back('{4'd7, 1'($urandom)}); q.push_back('{4'd8, 1'($urandom)});
      end else if (op == 6'b100011) begin
        q.push_back('{4'd3, 1'($urandom)});
        for (int k = $urandom_range(0, 2); k > 0; k--) q.push_back('{4'd4, 1'b0});
        q.push_back('{4'd4, 1'b1}); q.push_back('{4'd5, 1'($urandom)});
      end else if (op == 6'b101011) begin
        q.push_back('{4'd3, 1'($urandom)});
        for (int k = $urandom_range(0, 2); k > 0; k--) q.push_back('{4'd6, 1'b0});
        q.push_back('{4'd6, 1'b1});
      end else if (op == 6'b000100) begin
        q.push_back('{4'd9, 1'($urandom)});
      end else if (op == 6'b000010) begin
        q.push_back('{4'd12, 1'($urandom)});
      end else if (legal_op(op)) begin
        q.push_back('{4'd10, 1'($urandom)}); q.push_back('{4'd11, 1'($urandom)});
      end
      foreach (q[i]) begin
        z = 1'($urandom);
        cyc(q[i].mr, z);
        e = exp_out(q[i].st, op, q[i].mr, z);
        nvec++; if (obs_st !== q[i].st) begin
          nerr++; $display("FAIL rand_state n=%0d op=%b got %0d want %0d", n, op, obs_st, q[i].st);
        end
        nvec++; if (obs !== e) begin
          nerr++; $display("FAIL rand_outs n=%0d op=%b st=%0d got %h want %h", n, op, q[i].st, obs, e);
        end
      end
    end
  endtask

  initial begin
    bus.opcode = 6'b000000; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_imm();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
